// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the single-bus CPU control sequencer: opcodes, FSM states
// and the bundle of datapath control lines.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned WAIT_W   = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_XOR   = 3'd4,
    OP_JMP   = 3'd5,
    OP_BNE   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  // Encoding is exposed on state_dbg, so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_D    = 4'd4,
    S_M    = 4'd5,
    S_W    = 4'd6,
    S_X    = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic ACC_bus;
    logic load_ACC;
    logic PC_bus;
    logic load_PC;
    logic load_IR;
    logic load_MAR;
    logic MDR_bus;
    logic load_MDR;
    logic ALU_ACC;
    logic ALU_add;
    logic ALU_sub;
    logic ALU_xor;
    logic INC_PC;
    logic Addr_bus;
    logic CS;
    logic R_NW;
  } ctrl_t;

  // Quiescent control word: everything off, memory strobe parked at read.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c      = '0;
    c.R_NW = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Memory wait-state down-counter: loads on state entry, counts down while
// chip select is held, flags zero when the access may complete.
module wait_counter
  import cpu_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              n_reset,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_value,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_step_sequencer.sv
// Multi-cycle control FSM for the 8-bit single-bus CPU: drives every bus
// enable and register load, with memory wait states, run/step and HALT.
module bus_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned OP_W        = 3,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            run,
  input  logic            step,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_xor,
  output logic            INC_PC,
  output logic            Addr_bus,
  output logic            CS,
  output logic            R_NW,
  output logic            halted,
  output logic [3:0]      state_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  // Datapath width only matters to the surrounding CPU; it must hold an opcode.
  if (WORD_W < OPCODE_W) begin : g_word_too_narrow
  end

  state_t  state, next_state;
  ctrl_t   ctrl;
  opcode_t opc;
  logic    halt_now;
  logic    wait_load, wait_dec, wait_zero;

  assign opc = opcode_t'(op[OPCODE_W-1:0]);

  wait_counter u_wait (
    .clock      (clock),
    .n_reset    (n_reset),
    .load       (wait_load),
    .dec        (wait_dec),
    .load_value (WAIT_INIT),
    .zero       (wait_zero)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    ctrl       = ctrl_idle();
    halt_now   = 1'b0;
    wait_dec   = 1'b0;
    unique case (state)
      S_IDLE: if (run || step) next_state = S_F0;
      S_F0: begin
        ctrl.PC_bus   = 1'b1;
        ctrl.load_MAR = 1'b1;
        ctrl.INC_PC   = 1'b1;
        next_state    = S_F1;
      end
      S_F1: begin
        ctrl.CS = 1'b1;
        if (wait_zero) begin
          ctrl.load_MDR = 1'b1;
          next_state    = S_F2;
        end else begin
          wait_dec = 1'b1;
        end
      end
      S_F2: begin
        ctrl.MDR_bus = 1'b1;
        ctrl.load_IR = 1'b1;
        next_state   = S_D;
      end
      S_D: begin
        case (opc)
          OP_JMP: begin
            ctrl.Addr_bus = 1'b1;
            ctrl.load_PC  = 1'b1;
            next_state    = S_IDLE;
          end
          OP_BNE: begin
            ctrl.Addr_bus = !z_flag;
            ctrl.load_PC  = !z_flag;
            next_state    = S_IDLE;
          end
          OP_HALT: next_state = S_HALT;
          default: begin
            ctrl.Addr_bus = 1'b1;
            ctrl.load_MAR = 1'b1;
            next_state    = S_M;
          end
        endcase
      end
      S_M: begin
        if (opc == OP_STORE) begin
          ctrl.ACC_bus  = 1'b1;
          ctrl.load_MDR = 1'b1;
          next_state    = S_W;
        end else begin
          ctrl.CS = 1'b1;
          if (wait_zero) begin
            ctrl.load_MDR = 1'b1;
            next_state    = S_X;
          end else begin
            wait_dec = 1'b1;
          end
        end
      end
      S_W: begin
        ctrl.CS   = 1'b1;
        ctrl.R_NW = 1'b0;
        if (wait_zero) next_state = S_IDLE;
        else           wait_dec   = 1'b1;
      end
      S_X: begin
        ctrl.MDR_bus  = 1'b1;
        ctrl.load_ACC = 1'b1;
        ctrl.ALU_ACC  = (opc != OP_LOAD);
        ctrl.ALU_add  = (opc == OP_ADD);
        ctrl.ALU_sub  = (opc == OP_SUB);
        ctrl.ALU_xor  = (opc == OP_XOR);
        next_state    = S_IDLE;
      end
      S_HALT: halt_now = 1'b1;
      default: next_state = S_IDLE;
    endcase
    // Reloading on every state change arms the counter for whichever memory state is entered.
    wait_load = (next_state != state);
  end

  assign ACC_bus   = ctrl.ACC_bus;
  assign load_ACC  = ctrl.load_ACC;
  assign PC_bus    = ctrl.PC_bus;
  assign load_PC   = ctrl.load_PC;
  assign load_IR   = ctrl.load_IR;
  assign load_MAR  = ctrl.load_MAR;
  assign MDR_bus   = ctrl.MDR_bus;
  assign load_MDR  = ctrl.load_MDR;
  assign ALU_ACC   = ctrl.ALU_ACC;
  assign ALU_add   = ctrl.ALU_add;
  assign ALU_sub   = ctrl.ALU_sub;
  assign ALU_xor   = ctrl.ALU_xor;
  assign INC_PC    = ctrl.INC_PC;
  assign Addr_bus  = ctrl.Addr_bus;
  assign CS        = ctrl.CS;
  assign R_NW      = ctrl.R_NW;
  assign halted    = halt_now;
  assign state_dbg = state;

endmodule

// File: tb/tb_bus_step_sequencer.sv
// Directed bench: a small PC/IR/MAR/MDR/ACC/memory model closes the loop around
// the sequencer; expected instruction results are queued and popped on completion.
module tb_bus_step_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int unsigned WS      = 2;
  localparam int unsigned LEN_MEM = 6 + 2 * WS;
  localparam int unsigned LEN_JMP = 4 + WS;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [2:0] op;
  logic       z_flag;
  logic ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR;
  logic ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW;
  logic       halted;
  logic [3:0] state_dbg;

  bus_step_sequencer #(.WORD_W(8), .OP_W(3), .WAIT_STATES(WS)) dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag), .run(run), .step(step),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
    .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
    .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_xor(ALU_xor),
    .INC_PC(INC_PC), .Addr_bus(Addr_bus), .CS(CS), .R_NW(R_NW),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  logic [15:0] ctrl_vec;
  assign ctrl_vec = {ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
                     ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW};

  // Datapath model: instruction = op[7:5], addr[4:0]
  logic [7:0] mem [0:31];
  logic [4:0] pc, mar;
  logic [7:0] ir, mdr, acc, bus;
  logic       poke_en = 1'b0;
  logic [4:0] poke_addr = '0;
  logic [7:0] poke_data = '0;

  always_comb begin
    bus = '0;
    if (PC_bus)        bus = {3'b000, pc};
    else if (Addr_bus) bus = {3'b000, ir[4:0]};
    else if (MDR_bus)  bus = mdr;
    else if (ACC_bus)  bus = acc;
  end
  assign op     = ir[7:5];
  assign z_flag = (acc == 8'h00);

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      pc <= '0; mar <= '0; ir <= '0; mdr <= '0; acc <= '0;
    end else begin
      if (load_MAR) mar <= bus[4:0];
      if (load_PC)     pc <= bus[4:0];
      else if (INC_PC) pc <= pc + 5'd1;
      if (load_IR)  ir <= bus;
      if (load_MDR) mdr <= CS ? mem[mar] : bus;
      if (load_ACC) begin
        if (!ALU_ACC)     acc <= bus;
        else if (ALU_add) acc <= acc + bus;
        else if (ALU_sub) acc <= acc - bus;
        else if (ALU_xor) acc <= acc ^ bus;
      end
    end
  end

  always @(posedge clock) begin
    if (poke_en)                          mem[poke_addr] <= poke_data;
    else if (n_reset && CS && !R_NW)      mem[mar] <= mdr;
  end

  // Per-cycle monitors
  int unsigned cs_f1_cnt = 0, cs_w_cnt = 0, wr_w_cnt = 0, acc_mdr_cnt = 0;
  int unsigned pc_load_cnt = 0, f0_cnt = 0, bus_viol = 0;
  always @(negedge clock) begin
    if (state_dbg == S_F1 && CS) cs_f1_cnt++;
    if (state_dbg == S_W && CS) cs_w_cnt++;
    if (state_dbg == S_W && CS && !R_NW) wr_w_cnt++;
    if (load_ACC && MDR_bus) acc_mdr_cnt++;
    if (load_PC && Addr_bus) pc_load_cnt++;
    if (state_dbg == S_F0) f0_cnt++;
    assert ($countones({ACC_bus, PC_bus, MDR_bus, Addr_bus}) <= 1) else begin
      bus_viol++;
      $error("FAIL bus_onehot: observed %0d bus enables, expected at most 1",
             $countones({ACC_bus, PC_bus, MDR_bus, Addr_bus}));
    end
  end

  int unsigned checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int unsigned cycles;
    logic [7:0]  acc;
    logic [4:0]  pc;
  } exp_t;
  exp_t sb[$];

  task automatic expect_instr(input string tag, input int unsigned cycles,
                              input logic [7:0] a, input logic [4:0] p);
    exp_t e;
    e.tag = tag; e.cycles = cycles; e.acc = a; e.pc = p;
    sb.push_back(e);
  endtask

  task automatic compare_front(input int unsigned cycles);
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_cycles"}, cycles, e.cycles);
      chk({e.tag, "_acc"}, acc, e.acc);
      chk({e.tag, "_pc"}, pc, e.pc);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int unsigned limit,
                            output int unsigned n);
    n = 0;
    while (state_dbg !== s && n < limit) begin
      @(negedge clock);
      n++;
    end
    #1;
    chk({tag, "_reached"}, state_dbg, s);
  endtask

  // Launch one instruction from S_IDLE and count its non-idle cycles.
  task automatic run_one(input bit via_step, output int unsigned cycles);
    if (via_step) step = 1'b1;
    else          run  = 1'b1;
    @(negedge clock);
    step = 1'b0; run = 1'b0;
    cycles = 0;
    while (state_dbg != S_IDLE && cycles < 200) begin
      cycles++;
      @(negedge clock);
    end
    #1;
  endtask

  initial begin
    int unsigned n, cyc, snap_a, snap_b, snap_c;

    // Program: LOAD 1E; XOR 1D; STORE 1F; SUB 1F; BNE 04; ADD 1C; BNE 04
    poke(5'd0, 8'h1E); poke(5'd1, 8'h9D); poke(5'd2, 8'h3F); poke(5'd3, 8'h7F);
    poke(5'd4, 8'hC4); poke(5'd5, 8'h5C); poke(5'd6, 8'hC4);
    poke(5'h1E, 8'h5A); poke(5'h1D, 8'h69); poke(5'h1C, 8'h01); poke(5'h1F, 8'h00);

    // Reset held, then released with run=0 and no step
    chk("reset_state", state_dbg, 4'd0);
    chk("reset_ctrl", ctrl_vec, 16'h0001);
    chk("reset_halted", halted, 1'b0);
    @(negedge clock); n_reset = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    chk("idle_state", state_dbg, 4'd0);
    chk("idle_ctrl", ctrl_vec, 16'h0001);
    chk("idle_halted", halted, 1'b0);

    // Free run: LOAD then XOR, run drops during XOR
    expect_instr("load", LEN_MEM, 8'h5A, 5'd1);
    snap_a = acc_mdr_cnt;
    run = 1'b1;
    wait_state("load_f0", S_F0, 5, n);
    wait_state("load_idle", S_IDLE, 100, cyc);
    compare_front(cyc);
    chk("load_acc_pulses", acc_mdr_cnt - snap_a, 32'd1);
    wait_state("idle_cost", S_F0, 5, n);
    chk("idle_cycles_per_instr", n, 32'd1);
    expect_instr("xor", LEN_MEM, 8'h33, 5'd2);
    run = 1'b0;
    wait_state("xor_idle", S_IDLE, 100, cyc);
    compare_front(cyc);
    repeat (5) @(negedge clock);
    #1;
    chk("run_low_stays_idle", state_dbg, 4'd0);

    // STORE 1F with ACC=0x33
    snap_a = cs_f1_cnt; snap_b = cs_w_cnt; snap_c = wr_w_cnt;
    expect_instr("store", LEN_MEM, 8'h33, 5'd3);
    run_one(1'b0, cyc);
    compare_front(cyc);
    chk("store_cs_f1", cs_f1_cnt - snap_a, WS + 1);
    chk("store_cs_w", cs_w_cnt - snap_b, WS + 1);
    chk("store_rnw_low", wr_w_cnt - snap_c, WS + 1);
    chk("store_mem", mem[5'h1F], 8'h33);

    // SUB to zero, BNE not taken, ADD, BNE taken
    expect_instr("sub", LEN_MEM, 8'h00, 5'd4);
    run_one(1'b0, cyc);
    compare_front(cyc);
    snap_a = pc_load_cnt;
    expect_instr("bne_z1", LEN_JMP, 8'h00, 5'd5);
    run_one(1'b0, cyc);
    compare_front(cyc);
    chk("bne_z1_no_load_pc", pc_load_cnt - snap_a, 32'd0);
    expect_instr("add", LEN_MEM, 8'h01, 5'd6);
    run_one(1'b0, cyc);
    compare_front(cyc);
    snap_a = pc_load_cnt;
    expect_instr("bne_z0", LEN_JMP, 8'h01, 5'd4);
    run_one(1'b0, cyc);
    compare_front(cyc);
    chk("bne_z0_load_pc", pc_load_cnt - snap_a, 32'd1);

    // Single step: three pulses, the second one mid-instruction
    snap_a = f0_cnt;
    step = 1'b1; @(negedge clock); step = 1'b0;
    repeat (2) @(negedge clock);
    step = 1'b1; @(negedge clock); step = 1'b0;
    wait_state("step1_idle", S_IDLE, 50, n);
    repeat (3) @(negedge clock);
    step = 1'b1; @(negedge clock); step = 1'b0;
    wait_state("step2_idle", S_IDLE, 50, n);
    repeat (5) @(negedge clock);
    #1;
    chk("step_instr_count", f0_cnt - snap_a, 32'd2);
    chk("step_halted", halted, 1'b0);
    chk("step_pc", pc, 5'd4);

    // HALT is sticky until reset
    poke(5'd4, 8'hE0);
    step = 1'b1; @(negedge clock); step = 1'b0;
    wait_state("halt", S_HALT, 20, n);
    chk("halt_flag", halted, 1'b1);
    chk("halt_ctrl", ctrl_vec, 16'h0001);
    run = 1'b1; step = 1'b1;
    repeat (8) @(negedge clock);
    #1;
    chk("halt_sticky_state", state_dbg, 4'(S_HALT));
    chk("halt_sticky_ctrl", ctrl_vec, 16'h0001);
    run = 1'b0; step = 1'b0;
    n_reset = 1'b0;
    poke(5'd0, 8'h3E);
    @(negedge clock); n_reset = 1'b1;
    #1;
    chk("halt_cleared", halted, 1'b0);
    chk("halt_reset_state", state_dbg, 4'd0);

    // Reset during the write phase of a STORE drops CS at once
    run = 1'b1;
    wait_state("store2_w", S_W, 60, n);
    run = 1'b0;
    chk("store2_cs_before", {CS, R_NW}, 2'b10);
    n_reset = 1'b0;
    #1;
    chk("reset_drops_cs", CS, 1'b0);
    chk("reset_async_state", state_dbg, 4'd0);
    #2 n_reset = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    chk("post_reset_idle", state_dbg, 4'd0);
    chk("post_reset_ctrl", ctrl_vec, 16'h0001);
    chk("bus_onehot_total", bus_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
